// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: program counter, next-PC selection, IF/ID pipeline
// register, decoded instruction fields and a saturating redirect counter.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic [25:0] jidx,
  output logic [15:0] redirect_count
);

  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign redirect = jump | branch_taken;
  assign pc_plus4 = pc + 32'd4;

  // Jump beats branch, and any redirect beats a stall.
  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = {id_pc4[31:28], jump_index, 2'b00};
    else if (branch_taken)
      next_pc = branch_target;
    else if (stall)
      next_pc = pc;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= next_pc;
  end

  // A redirect discards the word fetched on the wrong path.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      id_valid <= 1'b0;
      id_instr <= 32'h0000_0000;
      id_pc4   <= 32'h0000_0000;
    end else if (!stall) begin
      id_valid <= 1'b1;
      id_instr <= imem_rdata;
      id_pc4   <= pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      redirect_count <= 16'h0000;
    else if (redirect && (redirect_count != 16'hFFFF))
      redirect_count <= redirect_count + 16'd1;
  end

  assign imem_addr = pc;

  // Fields read as zero whenever IF/ID holds a bubble.
  assign opcode = id_valid ? id_instr[31:26] : 6'd0;
  assign funct  = id_valid ? id_instr[5:0]   : 6'd0;
  assign rs     = id_valid ? id_instr[25:21] : 5'd0;
  assign rt     = id_valid ? id_instr[20:16] : 5'd0;
  assign rd     = id_valid ? id_instr[15:11] : 5'd0;
  assign shamt  = id_valid ? id_instr[10:6]  : 5'd0;
  assign imm    = id_valid ? id_instr[15:0]  : 16'd0;
  assign jidx   = id_valid ? id_instr[25:0]  : 26'd0;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Testbench for instr_fetch_stage: a spec-level reference model pushes the
// expected post-edge state into a scoreboard that a negedge monitor drains.
module tb_instr_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] imem_addr, imem_rdata, pc, id_instr, id_pc4;
  logic        id_valid;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm, redirect_count;
  logic [25:0] jidx;

  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .imm(imm), .jidx(jidx), .redirect_count(redirect_count)
  );

  // Instruction memory contents: a scrambled word per address, with an LW placed at 0x0040_0008.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0008) return 32'h8C48_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    int          cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // Reference model state: what the fetch stage should hold after each edge.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_cnt;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then queue its expectation after the edge.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t,
                      input logic j, input logic [25:0] ji);
    exp_t e;
    rst = r; stall = s; branch_taken = b; branch_target = t; jump = j; jump_index = ji;
    if (r) begin
      m_pc = RST_PC; m_valid = 1'b0; m_instr = 32'd0; m_pc4 = 32'd0; m_cnt = 0;
    end else begin
      logic [31:0] npc;
      if (j)      npc = (m_pc4 & 32'hF000_0000) | (32'(ji) * 4);
      else if (b) npc = t;
      else if (s) npc = m_pc;
      else        npc = m_pc + 32'd4;
      if (j || b) begin
        m_valid = 1'b0; m_instr = 32'd0; m_pc4 = 32'd0;
        m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      end else if (!s) begin
        m_valid = 1'b1; m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4;
      end
      m_pc = npc;
    end
    e.pc = m_pc; e.valid = m_valid; e.instr = m_instr; e.pc4 = m_pc4; e.cnt = m_cnt;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
  endtask

  // Monitor: every negedge after an edge the DUT presents its new state.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [31:0] w;
      e = sb.pop_front();
      w = e.valid ? e.instr : 32'd0;
      compare("pc",             pc,                     e.pc);
      compare("imem_addr",      imem_addr,              e.pc);
      compare("id_valid",       32'(id_valid),          32'(e.valid));
      compare("id_instr",       id_instr,               e.instr);
      compare("id_pc4",         id_pc4,                 e.pc4);
      compare("opcode",         32'(opcode),            w / 32'h0400_0000);
      compare("funct",          32'(funct),             w % 64);
      compare("rs",             32'(rs),                (w / 32'h0020_0000) % 32);
      compare("rt",             32'(rt),                (w / 32'h0001_0000) % 32);
      compare("rd",             32'(rd),                (w / 32'h0000_0800) % 32);
      compare("shamt",          32'(shamt),             (w / 64) % 32);
      compare("imm",            32'(imm),               w % 65536);
      compare("jidx",           32'(jidx),              w % 32'h0400_0000);
      compare("redirect_count", 32'(redirect_count),    32'(e.cnt));
    end
  end

  initial begin
    $display("[TB] start");
    // Reset then sequential fetch from 0x0040_0000.
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    compare("reset_pc", pc, 32'h0040_0000);
    compare("reset_valid", 32'(id_valid), 32'd0);
    idle(1);
    compare("seq_pc1", pc, 32'h0040_0004);
    compare("seq_first_pc4", id_pc4, 32'h0040_0004);
    compare("seq_first_valid", 32'(id_valid), 32'd1);
    idle(2);
    compare("lw_instr", id_instr, 32'h8C48_0004);
    compare("lw_opcode", 32'(opcode), 32'h23);

    // Three-cycle stall holds the LW in IF/ID.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
      compare("stall_pc", pc, 32'h0040_000C);
      compare("stall_opcode", 32'(opcode), 32'h23);
    end
    idle(1);
    compare("resume_pc", pc, 32'h0040_0010);

    // Taken branch together with stall.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 26'd0);
    compare("br_pc", pc, 32'h0000_0100);
    compare("br_bubble", 32'(id_valid), 32'd0);
    compare("br_count", 32'(redirect_count), 32'd1);
    idle(1);
    compare("br_target_word", id_instr, mem_word(32'h0000_0100));

    // Jump with id_pc4 = 0x1000_0008.
    step(1'b0, 1'b0, 1'b1, 32'h1000_0004, 1'b0, 26'd0);
    idle(1);
    compare("jmp_setup_pc4", id_pc4, 32'h1000_0008);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h000_0040);
    compare("jmp_pc", pc, 32'h1000_0100);

    // Jump and branch together: jump wins.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 26'd0);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 26'h000_0040);
    compare("jmp_beats_br", pc, 32'h0000_0100);

    // PC wrap.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'd0);
    idle(1);
    compare("wrap_pc", pc, 32'h0000_0000);
    compare("wrap_pc4", id_pc4, 32'h0000_0000);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 50) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
           $urandom, ($urandom % 10) == 0, 26'($urandom));
    end

    // Drive enough redirects to saturate the counter.
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    for (int i = 0; i < 65540; i++) begin
      step(1'b0, ($urandom % 2) == 1, 1'b1, $urandom & 32'hFFFF_FFFC, ($urandom % 16) == 0, 26'($urandom));
    end
    compare("sat_count", 32'(redirect_count), 32'h0000_FFFF);
    idle(2);
    compare("sat_hold", 32'(redirect_count), 32'h0000_FFFF);

    // Reset during a stall (and a redirect) restores every reset value.
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b1, 26'h3FF_FFFF);
    compare("rst_stall_pc", pc, 32'h0040_0000);
    compare("rst_stall_valid", 32'(id_valid), 32'd0);
    compare("rst_stall_instr", id_instr, 32'd0);
    compare("rst_stall_count", 32'(redirect_count), 32'd0);
    idle(3);

    @(negedge clk);
    #1;
    compare("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
